// File: rtl/bme280_meas_seq_pkg.sv
// Shared BME280 register map, sequencer state encoding and the raw measurement record.
package bme280_meas_seq_pkg;

  localparam logic [7:0] REG_ID        = 8'hD0;
  localparam logic [7:0] REG_CTRL_HUM  = 8'hF2;
  localparam logic [7:0] REG_CTRL_MEAS = 8'hF4;
  localparam logic [7:0] REG_CONFIG    = 8'hF5;
  localparam logic [7:0] REG_DATA      = 8'hF7;
  localparam logic [7:0] BME280_CHIP_ID = 8'h60;
  localparam int         BURST_LEN     = 8;

  typedef enum logic [3:0] {
    S_POR_WAIT,
    S_ID_RD,
    S_CFG_HUM,
    S_CFG_CFG,
    S_CFG_MEAS,
    S_WAIT_PER,
    S_BURST_RD,
    S_UPDATE,
    S_ERROR
  } state_e;

  typedef struct packed {
    logic [19:0] temp;
    logic [19:0] press;
    logic [15:0] hum;
  } meas_t;

  // States that own a controller transaction
  function automatic logic is_xfer(input state_e s);
    return (s == S_ID_RD) || (s == S_CFG_HUM) || (s == S_CFG_CFG) ||
           (s == S_CFG_MEAS) || (s == S_BURST_RD);
  endfunction

endpackage

// File: rtl/bme280_meas_seq_xfer_port.sv
// Transaction port toward bme280_i2c_ctrl: open/close tracking, byte counting,
// start/last generation and the received-byte buffer.
module bme280_meas_seq_xfer_port
  import bme280_meas_seq_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int NBUF   = BURST_LEN
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic                        load,
  input  logic                        ld_rdwr,
  input  logic [DWIDTH-1:0]           ld_addr,
  input  logic [DWIDTH-1:0]           ld_txd,
  input  logic [2:0]                  ld_nb_m1,
  input  logic                        I2C_done,
  input  logic [DWIDTH-1:0]           I2C_rxd,
  output logic                        I2C_start,
  output logic                        I2C_rdwr,
  output logic                        I2C_last,
  output logic [DWIDTH-1:0]           I2C_addr,
  output logic [DWIDTH-1:0]           I2C_txd,
  output logic                        xfer_act,
  output logic                        xfer_fin,
  output logic [NBUF-1:0][DWIDTH-1:0] rx_buf
);

  logic [2:0] rx_cnt;
  logic [2:0] nb_m1_q;
  logic       byte_ok;

  assign byte_ok  = xfer_act & I2C_done;
  assign xfer_fin = byte_ok & I2C_last;
  // Mask the final-done cycle so the controller cannot see a second request
  // while it falls back to idle.
  assign I2C_start = xfer_act & ~(I2C_done & I2C_last);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      xfer_act <= 1'b0;
      rx_cnt   <= '0;
      nb_m1_q  <= '0;
      I2C_last <= 1'b0;
      I2C_rdwr <= 1'b0;
      I2C_addr <= '0;
      I2C_txd  <= '0;
    end else if (load) begin
      xfer_act <= 1'b1;
      rx_cnt   <= '0;
      nb_m1_q  <= ld_nb_m1;
      I2C_last <= (ld_nb_m1 == 3'd0);
      I2C_rdwr <= ld_rdwr;
      I2C_addr <= ld_addr;
      I2C_txd  <= ld_txd;
    end else if (xfer_fin) begin
      xfer_act <= 1'b0;
      rx_cnt   <= '0;
      I2C_last <= 1'b0;
      I2C_rdwr <= 1'b0;
      I2C_addr <= '0;
      I2C_txd  <= '0;
    end else if (byte_ok) begin
      rx_cnt   <= rx_cnt + 3'd1;
      I2C_last <= ((rx_cnt + 3'd1) == nb_m1_q);
    end
  end

  for (genvar g = 0; g < NBUF; g++) begin : g_buf
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)                             rx_buf[g] <= '0;
      else if (byte_ok && rx_cnt == 3'(g))    rx_buf[g] <= I2C_rxd;
    end
  end

endmodule

// File: rtl/bme280_meas_seq.sv
// BME280 measurement sequencer: power-on wait, chip-ID check, configuration,
// then periodic 8-byte data bursts published as raw T/P/H words.
module bme280_meas_seq
  import bme280_meas_seq_pkg::*;
#(
  parameter int         DWIDTH     = 8,
  parameter int         POR_CYCLES = 100_000,
  parameter int         PERIOD_CYC = 5_000_000,
  parameter logic [2:0] OSRS_T     = 3'b001,
  parameter logic [2:0] OSRS_P     = 3'b001,
  parameter logic [2:0] OSRS_H     = 3'b001,
  parameter logic [2:0] T_SB       = 3'b000,
  parameter logic [2:0] FILTER     = 3'b000,
  parameter logic [7:0] CHIP_ID    = BME280_CHIP_ID
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Enable,
  output logic              I2C_start,
  output logic              I2C_rdwr,
  output logic              I2C_last,
  output logic [DWIDTH-1:0] I2C_addr,
  output logic [DWIDTH-1:0] I2C_txd,
  input  logic [DWIDTH-1:0] I2C_rxd,
  input  logic              I2C_done,
  output logic [19:0]       Temp_raw,
  output logic [19:0]       Press_raw,
  output logic [15:0]       Hum_raw,
  output logic              Meas_valid,
  output logic              Busy,
  output logic              Id_err
);

  localparam int PCW = $clog2(POR_CYCLES + 1);
  localparam int QCW = $clog2(PERIOD_CYC + 1);

  state_e                             state_q, state_d;
  logic                               entry_q;
  logic [PCW-1:0]                     por_cnt;
  logic [QCW-1:0]                     per_cnt;
  logic                               load;
  logic                               ld_rdwr;
  logic [DWIDTH-1:0]                  ld_addr, ld_txd;
  logic [2:0]                         ld_nb_m1;
  logic                               xfer_act, xfer_fin;
  logic                               id_bad;
  logic [BURST_LEN-1:0][DWIDTH-1:0]   rx_buf;
  meas_t                              meas_q, meas_d;
  logic                               unused_lsbs;

  // Transaction opens the cycle after state entry, guaranteeing an idle gap
  // between back-to-back transactions.
  assign load   = entry_q & is_xfer(state_q);
  assign id_bad = (I2C_rxd[7:0] != CHIP_ID);

  always_comb begin
    ld_rdwr  = 1'b0;
    ld_addr  = '0;
    ld_txd   = '0;
    ld_nb_m1 = 3'd0;
    case (state_q)
      S_ID_RD: begin
        ld_rdwr = 1'b1;
        ld_addr = DWIDTH'(REG_ID);
      end
      S_CFG_HUM: begin
        ld_addr = DWIDTH'(REG_CTRL_HUM);
        ld_txd  = DWIDTH'({5'b0, OSRS_H});
      end
      S_CFG_CFG: begin
        ld_addr = DWIDTH'(REG_CONFIG);
        ld_txd  = DWIDTH'({T_SB, FILTER, 2'b00});
      end
      S_CFG_MEAS: begin
        ld_addr = DWIDTH'(REG_CTRL_MEAS);
        ld_txd  = DWIDTH'({OSRS_T, OSRS_P, 2'b11});
      end
      S_BURST_RD: begin
        ld_rdwr  = 1'b1;
        ld_addr  = DWIDTH'(REG_DATA);
        ld_nb_m1 = 3'(BURST_LEN - 1);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_POR_WAIT: if (por_cnt == PCW'(POR_CYCLES - 1)) state_d = S_ID_RD;
      S_ID_RD:    if (xfer_fin) state_d = id_bad ? S_ERROR : S_CFG_HUM;
      S_CFG_HUM:  if (xfer_fin) state_d = S_CFG_CFG;
      S_CFG_CFG:  if (xfer_fin) state_d = S_CFG_MEAS;
      S_CFG_MEAS: if (xfer_fin) state_d = S_WAIT_PER;
      S_WAIT_PER: if (Enable && per_cnt == QCW'(PERIOD_CYC - 1)) state_d = S_BURST_RD;
      S_BURST_RD: if (xfer_fin) state_d = S_UPDATE;
      S_UPDATE:   state_d = S_WAIT_PER;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_POR_WAIT;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_POR_WAIT;
      entry_q <= 1'b0;
      por_cnt <= '0;
      per_cnt <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= (state_d != state_q);
      if (state_q == S_POR_WAIT) por_cnt <= por_cnt + 1'b1;
      // Period count restarts on every entry and while measurements are disabled
      if (state_q == S_WAIT_PER && state_d == S_WAIT_PER && Enable) per_cnt <= per_cnt + 1'b1;
      else                                                          per_cnt <= '0;
    end
  end

  always_comb begin
    meas_d       = meas_q;
    meas_d.press = {rx_buf[0][7:0], rx_buf[1][7:0], rx_buf[2][7:4]};
    meas_d.temp  = {rx_buf[3][7:0], rx_buf[4][7:0], rx_buf[5][7:4]};
    meas_d.hum   = {rx_buf[6][7:0], rx_buf[7][7:0]};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      meas_q     <= '0;
      Meas_valid <= 1'b0;
      Id_err     <= 1'b0;
    end else begin
      Meas_valid <= (state_q == S_UPDATE);
      if (state_q == S_UPDATE) meas_q <= meas_d;
      if (state_q == S_ID_RD && xfer_fin && id_bad) Id_err <= 1'b1;
    end
  end

  assign Temp_raw    = meas_q.temp;
  assign Press_raw   = meas_q.press;
  assign Hum_raw     = meas_q.hum;
  assign Busy        = xfer_act;
  assign unused_lsbs = ^{rx_buf[2][3:0], rx_buf[5][3:0]};

  bme280_meas_seq_xfer_port #(
    .DWIDTH (DWIDTH),
    .NBUF   (BURST_LEN)
  ) u_port (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .load      (load),
    .ld_rdwr   (ld_rdwr),
    .ld_addr   (ld_addr),
    .ld_txd    (ld_txd),
    .ld_nb_m1  (ld_nb_m1),
    .I2C_done  (I2C_done),
    .I2C_rxd   (I2C_rxd),
    .I2C_start (I2C_start),
    .I2C_rdwr  (I2C_rdwr),
    .I2C_last  (I2C_last),
    .I2C_addr  (I2C_addr),
    .I2C_txd   (I2C_txd),
    .xfer_act  (xfer_act),
    .xfer_fin  (xfer_fin),
    .rx_buf    (rx_buf)
  );

endmodule

// File: tb/tb_bme280_meas_seq.sv
// Scoreboard bench for bme280_meas_seq with a behavioural controller/sensor responder.
module tb_bme280_meas_seq;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Enable = 1'b0;
  logic        I2C_start, I2C_rdwr, I2C_last, I2C_done;
  logic [7:0]  I2C_addr, I2C_txd, I2C_rxd;
  logic [19:0] Temp_raw, Press_raw;
  logic [15:0] Hum_raw;
  logic        Meas_valid, Busy, Id_err;

  always #5 Clk = ~Clk;

  bme280_meas_seq #(
    .DWIDTH     (8),
    .POR_CYCLES (16),
    .PERIOD_CYC (64)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Enable     (Enable),
    .I2C_start  (I2C_start),
    .I2C_rdwr   (I2C_rdwr),
    .I2C_last   (I2C_last),
    .I2C_addr   (I2C_addr),
    .I2C_txd    (I2C_txd),
    .I2C_rxd    (I2C_rxd),
    .I2C_done   (I2C_done),
    .Temp_raw   (Temp_raw),
    .Press_raw  (Press_raw),
    .Hum_raw    (Hum_raw),
    .Meas_valid (Meas_valid),
    .Busy       (Busy),
    .Id_err     (Id_err)
  );

  // Sensor register image seen by reads
  logic [7:0] mem [256];
  logic       m_busy;
  int         m_dly, m_k;
  logic [7:0] m_a;

  // Controller responder: a few idle cycles per byte, then a one-cycle done
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_busy   <= 1'b0;
      m_dly    <= 0;
      m_k      <= 0;
      m_a      <= 8'h00;
      I2C_done <= 1'b0;
      I2C_rxd  <= 8'h00;
    end else begin
      I2C_done <= 1'b0;
      if (!m_busy) begin
        if (I2C_start) begin
          m_busy <= 1'b1;
          m_dly  <= 3;
          m_k    <= 0;
          m_a    <= I2C_addr;
        end
      end else if (m_dly != 0) begin
        m_dly <= m_dly - 1;
      end else begin
        I2C_done <= 1'b1;
        I2C_rxd  <= I2C_rdwr ? mem[m_a + 8'(m_k)] : 8'h00;
        m_k      <= m_k + 1;
        if (I2C_last) m_busy <= 1'b0;
        else          m_dly  <= 3;
      end
    end
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    bit          kind;   // 0 = transaction, 1 = measurement
    bit          rdwr;
    logic [7:0]  addr;
    logic [7:0]  txd;
    int          nb;
    logic [19:0] t, p;
    logic [15:0] h;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;
  int start_cnt = 0, meas_cnt = 0, last_start_cyc = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_xfer(input bit rw, input logic [7:0] a, input logic [7:0] d, input int nb);
    exp_t e;
    e = '{kind: 1'b0, rdwr: rw, addr: a, txd: d, nb: nb, t: '0, p: '0, h: '0};
    q.push_back(e);
  endtask

  task automatic push_meas(input logic [19:0] t, input logic [19:0] p, input logic [15:0] h);
    exp_t e;
    e = '{kind: 1'b1, rdwr: 1'b0, addr: '0, txd: '0, nb: 0, t: t, p: p, h: h};
    q.push_back(e);
  endtask

  task automatic push_cfg();
    push_xfer(1'b1, 8'hD0, 8'h00, 1);
    push_xfer(1'b0, 8'hF2, 8'h01, 1);
    push_xfer(1'b0, 8'hF5, 8'h00, 1);
    push_xfer(1'b0, 8'hF4, 8'h27, 1);
  endtask

  task automatic set_data(input logic [63:0] d);
    for (int i = 0; i < 8; i++) mem[8'hF7 + i] = d[63 - 8*i -: 8];
  endtask

  task automatic wait_idle(input int budget, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge Clk); #1;
      ok = (q.size() == 0) && !Busy && !m_busy;
    end
    chk(ok, nm, q.size(), 0);
  endtask

  task automatic wait_meas(input int n, input int budget, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge Clk); #1;
      ok = (meas_cnt >= n);
    end
    chk(ok, nm, meas_cnt, n);
  endtask

  task automatic wait_k(input int n, input int budget, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge Clk); #1;
      ok = m_busy && (m_k >= n);
    end
    chk(ok, nm, m_k, n);
  endtask

  // Monitor: pops the scoreboard whenever the DUT opens a transaction or publishes data
  initial begin
    logic st_p, fin_p, mv_p;
    int   bcnt, exp_nb;
    exp_t e;
    st_p = 1'b0; fin_p = 1'b0; mv_p = 1'b0; bcnt = 0; exp_nb = 0;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        st_p = 1'b0; fin_p = 1'b0; mv_p = 1'b0; bcnt = 0;
      end else begin
        if (fin_p) chk(!I2C_start, "start_after_final_done", 32'(I2C_start), 0);
        if (I2C_start && !st_p) begin
          start_cnt++;
          last_start_cyc = cyc;
          bcnt = 0;
          if (q.size() == 0 || q[0].kind) begin
            chk(1'b0, "unexpected_start", 32'(I2C_addr), 0);
            exp_nb = 0;
          end else begin
            e = q.pop_front();
            chk({I2C_rdwr, I2C_addr, I2C_txd} == {e.rdwr, e.addr, e.txd}, "xfer_header",
                32'({I2C_rdwr, I2C_addr, I2C_txd}), 32'({e.rdwr, e.addr, e.txd}));
            exp_nb = e.nb;
          end
        end
        if (I2C_done && Busy) begin
          bcnt++;
          if (I2C_last) chk(bcnt == exp_nb, "xfer_length", bcnt, exp_nb);
        end
        if (Meas_valid) begin
          meas_cnt++;
          chk(!mv_p, "valid_single_pulse", 32'(mv_p), 0);
          if (q.size() == 0 || !q[0].kind) begin
            chk(1'b0, "unexpected_meas", 32'(Temp_raw), 0);
          end else begin
            e = q.pop_front();
            chk(Temp_raw == e.t, "temp_raw", 32'(Temp_raw), 32'(e.t));
            chk(Press_raw == e.p, "press_raw", 32'(Press_raw), 32'(e.p));
            chk(Hum_raw == e.h, "hum_raw", 32'(Hum_raw), 32'(e.h));
          end
        end
        fin_p = I2C_done & I2C_last;
        st_p  = I2C_start;
        mv_p  = Meas_valid;
      end
    end
  end

  initial begin
    int s, en_cyc;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'hD0] = 8'h60;
    set_data(64'h5000_0080_0000_6600);

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    chk(!Busy && !I2C_start && !Meas_valid && !Id_err, "reset_flags",
        32'({Busy, I2C_start, Meas_valid, Id_err}), 0);
    chk(I2C_addr == 8'h00 && !I2C_rdwr && !I2C_last, "reset_port",
        32'({I2C_rdwr, I2C_last, I2C_addr}), 0);
    chk({Temp_raw, Press_raw, Hum_raw} == '0, "reset_raw", 32'(Temp_raw), 0);

    // Power-on wait, ID check and configuration
    push_cfg();
    @(posedge Clk); #1 Rst_n = 1'b1;
    repeat (16) @(posedge Clk);
    #1 chk(start_cnt == 0, "por_quiet", start_cnt, 0);
    repeat (2) @(posedge Clk);
    #1 chk(start_cnt == 1, "por_first_start", start_cnt, 1);
    wait_idle(500, "config_done");
    chk(!Id_err, "id_ok", 32'(Id_err), 0);

    // Disabled: no bursts
    repeat (200) @(posedge Clk);
    #1 chk(start_cnt == 4, "no_burst_when_disabled", start_cnt, 4);

    // Enable: first burst after the period
    push_xfer(1'b1, 8'hF7, 8'h00, 8);
    push_meas(20'h80000, 20'h50000, 16'h6600);
    en_cyc = cyc;
    Enable = 1'b1;
    wait_meas(1, 500, "burst_a_done");
    chk(last_start_cyc - en_cyc >= 64 && last_start_cyc - en_cyc <= 68, "burst_latency",
        last_start_cyc - en_cyc, 65);

    // Second burst; Enable drops mid-burst, burst still completes and publishes
    set_data(64'hABCD_EF12_3456_789A);
    push_xfer(1'b1, 8'hF7, 8'h00, 8);
    push_meas(20'h12345, 20'hABCDE, 16'h789A);
    wait_k(2, 300, "burst_b_started");
    Enable = 1'b0;
    wait_meas(2, 300, "burst_b_done");
    s = start_cnt;
    repeat (150) @(posedge Clk);
    #1 chk(start_cnt == s, "halt_after_disable", start_cnt, s);

    // Reset in the middle of a burst, then a clean restart
    push_xfer(1'b1, 8'hF7, 8'h00, 8);
    Enable = 1'b1;
    wait_k(4, 300, "burst_c_byte4");
    Rst_n = 1'b0;
    #1;
    chk({Temp_raw, Press_raw, Hum_raw} == '0, "midburst_reset_raw", 32'(Press_raw), 0);
    chk(!Busy && !I2C_start && I2C_addr == 8'h00 && !I2C_rdwr, "midburst_reset_port",
        32'({Busy, I2C_start, I2C_rdwr, I2C_addr}), 0);
    Enable = 1'b0;
    s = start_cnt;
    repeat (2) @(posedge Clk);
    push_cfg();
    #1 Rst_n = 1'b1;
    wait_idle(500, "restart_config_done");
    chk(start_cnt == s + 4, "restart_xfer_count", start_cnt, s + 4);

    // Wrong chip ID: error is sticky and the bus stays quiet
    mem[8'hD0] = 8'h58;
    Enable = 1'b1;
    Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    push_xfer(1'b1, 8'hD0, 8'h00, 1);
    s = start_cnt;
    #1 Rst_n = 1'b1;
    repeat (300) @(posedge Clk);
    #1;
    chk(Id_err, "id_err_set", 32'(Id_err), 1);
    chk(!Busy, "id_err_not_busy", 32'(Busy), 0);
    chk(start_cnt == s + 1, "id_err_no_more_starts", start_cnt, s + 1);
    chk(q.size() == 0, "scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
